// File: rtl/dma_pkg.sv
// Shared definitions for the single-channel word-copy DMA: register offsets,
// CTRL bit positions and FSM state encoding.
package dma_pkg;

    // Register select values taken from address bits [3:2]
    localparam logic [1:0] REG_SRC  = 2'd0;
    localparam logic [1:0] REG_DST  = 2'd1;
    localparam logic [1:0] REG_LEN  = 2'd2;
    localparam logic [1:0] REG_CTRL = 2'd3;

    localparam int CTRL_START  = 0;
    localparam int CTRL_BUSY   = 1;
    localparam int CTRL_DONE   = 2;
    localparam int CTRL_ERR    = 3;
    localparam int CTRL_IRQ_EN = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2
    } state_t;

endpackage

// File: rtl/dma_regs.sv
// DMA register file and register-port decode. The completion interrupt and
// the IRQ_EN control bit exist only when DMA_IRQ_EN is defined.
module dma_regs
    import dma_pkg::*;
#(
    parameter int LEN_BITS = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          reg_sel,
    input  logic                sel_in,
    input  logic                read_in,
    input  logic [3:0]          write_mask_in,
    input  logic [31:0]         write_value_in,
    output logic [31:0]         read_value_out,
    input  logic                busy,
    input  logic [LEN_BITS-1:0] remaining,
    input  logic                set_done,
    input  logic                set_err,
    input  logic                clear_flags,
    output logic [31:0]         src,
    output logic [31:0]         dst,
    output logic [LEN_BITS-1:0] len,
    output logic                start,
    output logic                irq_out
);

    logic [31:0]         src_reg;
    logic [31:0]         dst_reg;
    logic [LEN_BITS-1:0] len_reg;
    logic                done_reg;
    logic                err_reg;
    logic                irq_en;
    logic [31:0]         byte_en;
    logic [31:0]         len_merged;
    logic                wr_en;
    logic                wr_ctrl;

    for (genvar gi = 0; gi < 4; gi++) begin : g_byte_en
        assign byte_en[8*gi +: 8] = {8{write_mask_in[gi]}};
    end

    assign wr_en      = sel_in && (write_mask_in != 4'b0000);
    assign wr_ctrl    = wr_en && (reg_sel == REG_CTRL) && write_mask_in[0];
    assign start      = wr_ctrl && write_value_in[CTRL_START] && !busy;
    assign len_merged = (32'(len_reg) & ~byte_en) | (write_value_in & byte_en);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            src_reg  <= '0;
            dst_reg  <= '0;
            len_reg  <= '0;
            done_reg <= 1'b0;
            err_reg  <= 1'b0;
        end else begin
            if (wr_en && !busy) begin
                case (reg_sel)
                    REG_SRC: src_reg <= ((src_reg & ~byte_en) | (write_value_in & byte_en)) & 32'hFFFF_FFFC;
                    REG_DST: dst_reg <= ((dst_reg & ~byte_en) | (write_value_in & byte_en)) & 32'hFFFF_FFFC;
                    REG_LEN: len_reg <= len_merged[LEN_BITS-1:0];
                    default: ;
                endcase
            end
            // A hardware set always beats a coincident write-1-to-clear
            if (set_done)
                done_reg <= 1'b1;
            else if (clear_flags || (wr_ctrl && write_value_in[CTRL_DONE]))
                done_reg <= 1'b0;
            if (set_err)
                err_reg <= 1'b1;
            else if (clear_flags || (wr_ctrl && write_value_in[CTRL_ERR]))
                err_reg <= 1'b0;
        end
    end

`ifdef DMA_IRQ_EN
    logic irq_en_reg;
    logic irq_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_en_reg <= 1'b0;
            irq_reg    <= 1'b0;
        end else begin
            if (wr_ctrl)
                irq_en_reg <= write_value_in[CTRL_IRQ_EN];
            irq_reg <= irq_en_reg && (done_reg || err_reg);
        end
    end

    assign irq_en  = irq_en_reg;
    assign irq_out = irq_reg;
`else
    assign irq_en  = 1'b0;
    assign irq_out = 1'b0;
`endif

    always_comb begin
        read_value_out = '0;
        if (sel_in && read_in) begin
            case (reg_sel)
                REG_SRC: read_value_out = src_reg;
                REG_DST: read_value_out = dst_reg;
                REG_LEN: read_value_out = 32'(busy ? remaining : len_reg);
                default: begin
                    read_value_out[CTRL_BUSY]   = busy;
                    read_value_out[CTRL_DONE]   = done_reg;
                    read_value_out[CTRL_ERR]    = err_reg;
                    read_value_out[CTRL_IRQ_EN] = irq_en;
                end
            endcase
        end
    end

    assign src = src_reg;
    assign dst = dst_reg;
    assign len = len_reg;

endmodule

// File: rtl/dma.sv
// Single-channel memory-to-memory word copy engine (read then write per word).
// Define DMA_IRQ_EN to build the completion interrupt.
module dma
    import dma_pkg::*;
#(
    parameter int LEN_BITS = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address_in,
    input  logic        sel_in,
    input  logic        read_in,
    output logic [31:0] read_value_out,
    input  logic [3:0]  write_mask_in,
    input  logic [31:0] write_value_in,
    output logic        ready_out,
    output logic [31:0] address_out,
    output logic        read_out,
    output logic        write_out,
    output logic [3:0]  write_mask_out,
    output logic [31:0] write_value_out,
    input  logic [31:0] read_value_in,
    input  logic        ready_in,
    input  logic        fault_in,
    output logic        irq_out
);

    state_t              state_reg;
    logic [31:0]         src_ptr_reg;
    logic [31:0]         dst_ptr_reg;
    logic [LEN_BITS-1:0] count_reg;
    logic [31:0]         address_reg;
    logic                read_reg;
    logic                write_reg;
    logic [3:0]          mask_reg;
    logic [31:0]         data_reg;

    logic [31:0]         src;
    logic [31:0]         dst;
    logic [LEN_BITS-1:0] len;
    logic                start;
    logic                busy;
    logic                last_word;
    logic                set_done;
    logic                set_err;
    logic                clear_flags;
    logic                unused_addr_bits;

    assign unused_addr_bits = ^{address_in[31:4], address_in[1:0]};

    assign busy        = (state_reg != ST_IDLE);
    assign last_word   = (count_reg == LEN_BITS'(1));
    assign clear_flags = (state_reg == ST_IDLE) && start && (len != '0);
    assign set_err     = busy && ready_in && fault_in;
    assign set_done    = ((state_reg == ST_IDLE) && start && (len == '0))
                      || ((state_reg == ST_WR) && ready_in && !fault_in && last_word);

    dma_regs #(.LEN_BITS(LEN_BITS)) u_regs (
        .clk            (clk),
        .reset          (reset),
        .reg_sel        (address_in[3:2]),
        .sel_in         (sel_in),
        .read_in        (read_in),
        .write_mask_in  (write_mask_in),
        .write_value_in (write_value_in),
        .read_value_out (read_value_out),
        .busy           (busy),
        .remaining      (count_reg),
        .set_done       (set_done),
        .set_err        (set_err),
        .clear_flags    (clear_flags),
        .src            (src),
        .dst            (dst),
        .len            (len),
        .start          (start),
        .irq_out        (irq_out)
    );

    // Bus request outputs are registered alongside the state so they are glitch-free
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= ST_IDLE;
            src_ptr_reg <= '0;
            dst_ptr_reg <= '0;
            count_reg   <= '0;
            address_reg <= '0;
            read_reg    <= 1'b0;
            write_reg   <= 1'b0;
            mask_reg    <= '0;
            data_reg    <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start && (len != '0)) begin
                        state_reg   <= ST_RD;
                        src_ptr_reg <= src;
                        dst_ptr_reg <= dst;
                        count_reg   <= len;
                        address_reg <= src;
                        read_reg    <= 1'b1;
                    end
                end
                ST_RD: begin
                    if (ready_in) begin
                        read_reg <= 1'b0;
                        if (fault_in) begin
                            state_reg   <= ST_IDLE;
                            address_reg <= '0;
                        end else begin
                            state_reg   <= ST_WR;
                            address_reg <= dst_ptr_reg;
                            write_reg   <= 1'b1;
                            mask_reg    <= 4'b1111;
                            data_reg    <= read_value_in;
                        end
                    end
                end
                ST_WR: begin
                    if (ready_in) begin
                        write_reg <= 1'b0;
                        mask_reg  <= '0;
                        data_reg  <= '0;
                        if (fault_in || last_word) begin
                            state_reg   <= ST_IDLE;
                            address_reg <= '0;
                        end else begin
                            state_reg   <= ST_RD;
                            address_reg <= src_ptr_reg + 32'd4;
                            read_reg    <= 1'b1;
                        end
                        if (!fault_in) begin
                            src_ptr_reg <= src_ptr_reg + 32'd4;
                            dst_ptr_reg <= dst_ptr_reg + 32'd4;
                            count_reg   <= count_reg - LEN_BITS'(1);
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign ready_out       = sel_in;
    assign address_out     = address_reg;
    assign read_out        = read_reg;
    assign write_out       = write_reg;
    assign write_mask_out  = mask_reg;
    assign write_value_out = data_reg;

endmodule
